// File: rtl/video_mem_pkg.sv
// Shared constants and types for the Mandelbrot frame buffer
// writer and reader on the MIG user ports.
package video_mem_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int FRAME_BYTES = 70560;
    localparam int WORD_W      = 64;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Shared by the frame writer and reader.
module sync2 (
    input  logic clk0,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk0 or negedge nreset) begin
        if (!nreset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Fetches one frame from DDR2 via MIG port p1 in read bursts
// and streams the 64-bit words out over valid/ready.
module frame_reader
    import video_mem_pkg::*;
#(
    parameter int FRAME_BYTES = video_mem_pkg::FRAME_BYTES,
    parameter int BURST_WORDS = 32,
    parameter int ADDR_W      = 30
) (
    input  logic              clk0,
    input  logic              nreset,
    input  logic              calib_done,
    input  logic              frame_start,
    input  logic              frame_sel,
    output logic              p1_cmd_en,
    output logic [2:0]        p1_cmd_instr,
    output logic [5:0]        p1_cmd_bl,
    output logic [ADDR_W-1:0] p1_cmd_byte_addr,
    input  logic              p1_cmd_full,
    output logic              p1_rd_en,
    input  logic [WORD_W-1:0] p1_rd_data,
    input  logic              p1_rd_empty,
    output logic [WORD_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              start_overrun
);

    localparam int FRAME_WORDS = FRAME_BYTES / 8;
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int WL_W  = (CNT_W > 7) ? CNT_W : 7;

    rd_state_t state, state_nx;

    logic              calib_ok;
    logic [ADDR_W-1:0] addr;
    logic [WL_W-1:0]   words_left;
    logic [WL_W-1:0]   burst_len;
    logic [6:0]        burst_cnt;
    logic              accept;
    logic              xfer;
    logic              last_beat;

    sync2 u_calib_sync (
        .clk0   (clk0),
        .nreset (nreset),
        .d      (calib_done),
        .q      (calib_ok)
    );

    assign p1_cmd_instr = CMD_READ;

    assign burst_len = (words_left > WL_W'(BURST_WORDS))
                     ? WL_W'(BURST_WORDS) : words_left;

    assign accept    = frame_start & calib_ok & (state == RD_IDLE);
    assign pix_valid = (state == RD_DRAIN) & ~p1_rd_empty;
    assign pix_data  = pix_valid ? p1_rd_data : '0;
    assign xfer      = pix_valid & pix_ready;
    assign p1_rd_en  = xfer;
    assign last_beat = xfer & (burst_cnt == 7'd1);

    always_ff @(posedge clk0 or negedge nreset) begin
        if (!nreset) state <= RD_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RD_IDLE:  if (accept) state_nx = RD_ISSUE;
            RD_ISSUE: if (!p1_cmd_full) state_nx = RD_DRAIN;
            RD_DRAIN: begin
                if (last_beat) begin
                    if (words_left == WL_W'(1)) state_nx = RD_DONE;
                    else                        state_nx = RD_ISSUE;
                end
            end
            RD_DONE:  state_nx = RD_IDLE;
            default:  state_nx = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge nreset) begin
        if (!nreset) begin
            p1_cmd_en        <= 1'b0;
            p1_cmd_bl        <= '0;
            p1_cmd_byte_addr <= '0;
            addr             <= '0;
            words_left       <= '0;
            burst_cnt        <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            start_overrun    <= 1'b0;
        end else begin
            p1_cmd_en  <= 1'b0;
            frame_done <= 1'b0;
            // DONE still counts as busy for a competing start
            if (frame_start && state != RD_IDLE)
                start_overrun <= 1'b1;
            if (accept) begin
                addr       <= frame_sel ? '0 : ADDR_W'(FRAME_BYTES);
                words_left <= WL_W'(FRAME_WORDS);
                busy       <= 1'b1;
            end
            if (state == RD_ISSUE && !p1_cmd_full) begin
                p1_cmd_en        <= 1'b1;
                p1_cmd_bl        <= 6'(burst_len - WL_W'(1));
                p1_cmd_byte_addr <= addr;
                burst_cnt        <= 7'(burst_len);
            end
            // Per-word address step sums to burst_len*8 per burst
            if (xfer) begin
                addr       <= addr + ADDR_W'(8);
                words_left <= words_left - WL_W'(1);
                burst_cnt  <= burst_cnt - 7'd1;
                if (words_left == WL_W'(1)) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with a behavioural MIG
// read port and a word-by-word stream scoreboard.
module tb_frame_reader;
    import video_mem_pkg::*;

    localparam int FW = 8820;
    localparam int BW = 32;

    logic        clk0 = 1'b0;
    logic        nreset = 1'b0;
    logic        calib_done = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_sel = 1'b0;
    logic        p1_cmd_en;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic        p1_cmd_full = 1'b0;
    logic        p1_rd_en;
    logic [63:0] p1_rd_data = '0;
    logic        p1_rd_empty = 1'b1;
    logic [63:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic        start_overrun;

    always #5 clk0 = ~clk0;

    frame_reader #(
        .FRAME_BYTES (70560),
        .BURST_WORDS (32),
        .ADDR_W      (30)
    ) dut (
        .clk0             (clk0),
        .nreset           (nreset),
        .calib_done       (calib_done),
        .frame_start      (frame_start),
        .frame_sel        (frame_sel),
        .p1_cmd_en        (p1_cmd_en),
        .p1_cmd_instr     (p1_cmd_instr),
        .p1_cmd_bl        (p1_cmd_bl),
        .p1_cmd_byte_addr (p1_cmd_byte_addr),
        .p1_cmd_full      (p1_cmd_full),
        .p1_rd_en         (p1_rd_en),
        .p1_rd_data       (p1_rd_data),
        .p1_rd_empty      (p1_rd_empty),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .busy             (busy),
        .frame_done       (frame_done),
        .start_overrun    (start_overrun)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic [29:0] a);
        return {2'b10, ~a, 2'b01, a};
    endfunction

    function automatic logic [5:0] exp_bl(input int i);
        int rem;
        rem = FW - BW * i;
        return 6'(((rem > BW) ? BW : rem) - 1);
    endfunction

    // MIG model: each read command returns its burst into a FWFT queue
    logic [63:0] rdq[$];
    int model_err = 0;
    bit bp_mode = 0;

    always @(posedge clk0 or negedge nreset) begin
        if (!nreset) begin
            rdq.delete();
            p1_rd_empty <= 1'b1;
            p1_rd_data  <= '0;
        end else begin
            if (p1_rd_en) begin
                if (rdq.size() == 0) model_err++;
                else void'(rdq.pop_front());
            end
            if (p1_cmd_en)
                for (int k = 0; k <= int'(p1_cmd_bl); k++)
                    rdq.push_back(mkdata(p1_cmd_byte_addr + 30'(8 * k)));
            if (rdq.size() > 64) model_err++;
            p1_rd_empty <= (rdq.size() == 0);
            p1_rd_data  <= (rdq.size() > 0) ? rdq[0] : '0;
        end
    end

    always @(posedge clk0)
        pix_ready <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    // Scoreboard
    bit          mon_en = 0;
    logic [29:0] base = '0;
    int          cmd_idx = 0;
    int          word_idx = 0;
    int          done_cnt = 0;
    logic [29:0] first_addr = '0;
    logic [29:0] last_addr = '0;
    logic [5:0]  last_bl = '0;
    bit          prev_cmd = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;

    always @(negedge clk0) begin
        if (mon_en) begin
            if (p1_cmd_en) begin
                chk("cmd_instr", p1_cmd_instr, 3'b001);
                chk("cmd_single", prev_cmd, 0);
                chk("cmd_addr", p1_cmd_byte_addr, base + 30'(256 * cmd_idx));
                chk("cmd_bl", p1_cmd_bl, exp_bl(cmd_idx));
                if (cmd_idx == 0) first_addr = p1_cmd_byte_addr;
                last_addr = p1_cmd_byte_addr;
                last_bl = p1_cmd_bl;
                cmd_idx++;
            end
            prev_cmd = p1_cmd_en;
            if (prev_stall) begin
                chk("hold_valid", pix_valid, 1);
                chk("hold_data", pix_data, prev_data);
            end
            if (!pix_ready) chk("rd_en_stall", p1_rd_en, 0);
            if (pix_valid && pix_ready) begin
                chk("pix_data", pix_data, mkdata(base + 30'(8 * word_idx)));
                chk("rd_en_xfer", p1_rd_en, 1);
                word_idx++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data = pix_data;
            if (frame_done) begin
                done_cnt++;
                chk("done_words", word_idx, FW);
                chk("done_busy", busy, 0);
            end
        end
    end

    typedef struct {
        bit          sel;
        bit          bp;
        bit          stall;
        logic [29:0] e_first;
        logic [29:0] e_last;
        logic [5:0]  e_bl;
        int          e_ncmd;
        bit          e_ovr;
    } vec_t;

    task automatic run_frame(input vec_t v, input bit lat, input int ovr_at);
        int  cycles;
        bit  ovr_done;
        @(posedge clk0);
        #1;
        base = v.sel ? 30'd0 : 30'd70560;
        cmd_idx = 0;
        word_idx = 0;
        done_cnt = 0;
        prev_cmd = 0;
        prev_stall = 0;
        bp_mode = v.bp;
        mon_en = 1;
        if (v.stall) p1_cmd_full = 1'b1;
        frame_sel = v.sel;
        frame_start = 1'b1;
        @(posedge clk0);
        #1 frame_start = 1'b0;
        if (lat) begin
            @(negedge clk0);
            chk("lat_cycle1_cmd_en", p1_cmd_en, 0);
            chk("lat_busy", busy, 1);
            @(negedge clk0);
            chk("lat_cycle2_cmd_en", p1_cmd_en, 1);
            chk("lat_addr", p1_cmd_byte_addr, base);
        end
        if (v.stall) begin
            repeat (10) @(negedge clk0);
            chk("stall_no_cmd", cmd_idx, 0);
            chk("stall_busy", busy, 1);
            @(posedge clk0);
            #1 p1_cmd_full = 1'b0;
        end
        cycles = 0;
        ovr_done = 0;
        while (done_cnt == 0 && cycles < 40000) begin
            @(posedge clk0);
            #1;
            cycles++;
            frame_start = 1'b0;
            if (ovr_at > 0 && !ovr_done && word_idx >= ovr_at) begin
                frame_sel = ~v.sel;
                frame_start = 1'b1;
                ovr_done = 1;
            end
        end
        frame_start = 1'b0;
        chk("frame_timeout", cycles < 40000, 1);
        repeat (3) @(negedge clk0);
        chk("n_cmd", cmd_idx, v.e_ncmd);
        chk("first_addr", first_addr, v.e_first);
        chk("last_addr", last_addr, v.e_last);
        chk("last_bl", last_bl, v.e_bl);
        chk("n_words", word_idx, FW);
        chk("n_done", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("overrun_flag", start_overrun, v.e_ovr);
        mon_en = 0;
        bp_mode = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmd_en"}, p1_cmd_en, 0);
        chk({tag, "_bl"}, p1_cmd_bl, 0);
        chk({tag, "_addr"}, p1_cmd_byte_addr, 0);
        chk({tag, "_rd_en"}, p1_rd_en, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_overrun"}, start_overrun, 0);
        chk({tag, "_instr"}, p1_cmd_instr, 3'b001);
    endtask

    vec_t tbl[2];
    vec_t vr;

    initial begin
        int seen;
        int cyc;

        tbl[0] = '{0, 1, 0, 30'd70560, 30'd140960, 6'd19, 276, 1};
        tbl[1] = '{1, 0, 1, 30'd0, 30'd70400, 6'd19, 276, 1};
        vr     = '{0, 0, 0, 30'd70560, 30'd140960, 6'd19, 276, 0};

        #12;
        chk_zero("reset");
        @(posedge clk0);
        #1 nreset = 1'b1;

        // Start without calibration must be ignored
        repeat (2) @(posedge clk0);
        #1 frame_sel = 1'b1;
        frame_start = 1'b1;
        @(posedge clk0);
        #1 frame_start = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk0);
            if (p1_cmd_en || busy) seen++;
        end
        chk("nocalib_activity", seen, 0);
        chk("nocalib_overrun", start_overrun, 0);

        calib_done = 1'b1;
        repeat (3) @(posedge clk0);
        run_frame('{1, 0, 0, 30'd0, 30'd70400, 6'd19, 276, 1}, 1, 1000);

        for (int i = 0; i < 2; i++)
            run_frame(tbl[i], 0, 0);

        // Async reset in the middle of a burst drain
        @(posedge clk0);
        #1 base = 30'd70560;
        cmd_idx = 0;
        word_idx = 0;
        done_cnt = 0;
        prev_cmd = 0;
        prev_stall = 0;
        mon_en = 1;
        frame_sel = 1'b0;
        frame_start = 1'b1;
        @(posedge clk0);
        #1 frame_start = 1'b0;
        cyc = 0;
        while (word_idx < 500 && cyc < 2000) begin
            @(posedge clk0);
            cyc++;
        end
        chk("mid_frame_reached", word_idx >= 500, 1);
        @(posedge clk0);
        #2 nreset = 1'b0;
        mon_en = 0;
        #1;
        chk_zero("async_rst");
        @(negedge clk0);
        chk_zero("held_rst");
        @(posedge clk0);
        #1 nreset = 1'b1;
        repeat (4) @(posedge clk0);
        run_frame(vr, 1, 0);

        chk("mig_model_errors", model_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
